// File: rtl/kd_tree_query_scheduler.sv
// Build/query sequencer for the register-based KD-tree: loads node words, then issues patches from
// requesters A/B onto the dual tree lanes and forwards returned leaves. Optional ids: KDQ_QUERY_ID_EN.
module kd_tree_query_scheduler #(
    parameter int INTERNAL_WIDTH = 22,
    parameter int PATCH_WIDTH    = 55,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int NUM_NODES      = 63,
    parameter int LATENCY        = 6,
    parameter int QCNT_W         = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [QCNT_W-1:0]         num_queries,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    input  logic                      node_valid,
    input  logic [INTERNAL_WIDTH-1:0] node_data,
    output logic                      node_ready,
    input  logic                      qa_valid,
    input  logic [PATCH_WIDTH-1:0]    qa_patch,
    output logic                      qa_ready,
    input  logic                      qb_valid,
    input  logic [PATCH_WIDTH-1:0]    qb_patch,
    output logic                      qb_ready,
    output logic                      fsm_enable,
    output logic                      sender_enable,
    output logic [INTERNAL_WIDTH-1:0] sender_data,
    output logic                      patch_en,
    output logic                      patch_two_en,
    output logic [PATCH_WIDTH-1:0]    patch_in,
    output logic [PATCH_WIDTH-1:0]    patch_in_two,
    input  logic                      receiver_en,
    input  logic                      receiver_two_en,
    input  logic [ADDRESS_WIDTH-1:0]  leaf_index,
    input  logic [ADDRESS_WIDTH-1:0]  leaf_index_two,
    output logic                      res_a_valid,
    output logic                      res_b_valid,
    output logic [ADDRESS_WIDTH-1:0]  res_a_index,
    output logic [ADDRESS_WIDTH-1:0]  res_b_index,
    output logic [QCNT_W-1:0]         res_a_id,
    output logic [QCNT_W-1:0]         res_b_id
);
    localparam int LW = $clog2(NUM_NODES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_QUERY = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state, state_next;
    logic [QCNT_W-1:0] nq, issued, returned, issued_next, returned_next, room;
    logic [LW-1:0]     loaded, loaded_next;
    logic              node_fire, qa_fire, qb_fire, acc_a, acc_b, rejected, active;

    // Handshakes are plain valid/ready: a transfer happens in any cycle where both are high.
    assign active     = (state != S_IDLE);
    assign busy       = (state == S_LOAD) || (state == S_QUERY) || (state == S_DRAIN);
    assign done       = (state == S_DONE);
    assign fsm_enable = (state == S_LOAD);
    assign node_ready = (state == S_LOAD) && (loaded < LW'(NUM_NODES));
    assign qa_ready   = (state == S_QUERY) && (issued < nq);
    assign node_fire  = node_valid && node_ready;
    assign qa_fire    = qa_valid && qa_ready;
    // A takes the last free slot when both requesters compete for it.
    assign qb_ready   = (state == S_QUERY) && ((issued + QCNT_W'(qa_fire)) < nq);
    assign qb_fire    = qb_valid && qb_ready;

    assign room          = issued - returned;
    assign acc_a         = active && receiver_en && (room != '0);
    assign acc_b         = active && receiver_two_en && (acc_a ? (room >= QCNT_W'(2)) : (room != '0));
    assign rejected      = active && ((receiver_en && !acc_a) || (receiver_two_en && !acc_b));
    assign issued_next   = issued + QCNT_W'(qa_fire) + QCNT_W'(qb_fire);
    assign returned_next = returned + QCNT_W'(acc_a) + QCNT_W'(acc_b);
    assign loaded_next   = loaded + LW'(node_fire);

    // Exit conditions look at next-cycle counts so an empty run falls straight through to DONE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  if (loaded_next == LW'(NUM_NODES)) state_next = S_QUERY;
            S_QUERY: if (issued_next == nq)
                         state_next = (returned_next == issued_next) ? S_DONE : S_DRAIN;
            S_DRAIN: if (returned_next == issued) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            nq            <= '0;
            issued        <= '0;
            returned      <= '0;
            loaded        <= '0;
            err           <= 1'b0;
            sender_enable <= 1'b0;
            sender_data   <= '0;
            patch_en      <= 1'b0;
            patch_two_en  <= 1'b0;
            patch_in      <= '0;
            patch_in_two  <= '0;
            res_a_valid   <= 1'b0;
            res_b_valid   <= 1'b0;
            res_a_index   <= '0;
            res_b_index   <= '0;
        end else begin
            state <= state_next;
            if ((state == S_IDLE) && start) begin
                nq       <= num_queries;
                issued   <= '0;
                returned <= '0;
                loaded   <= '0;
                err      <= 1'b0;
            end else begin
                issued   <= issued_next;
                returned <= returned_next;
                loaded   <= loaded_next;
                if (rejected) err <= 1'b1;
            end
            sender_enable <= node_fire;
            if (node_fire) sender_data <= node_data;
            patch_en     <= qa_fire;
            patch_two_en <= qb_fire;
            if (qa_fire) patch_in <= qa_patch;
            if (qb_fire) patch_in_two <= qb_patch;
            res_a_valid <= acc_a;
            res_b_valid <= acc_b;
            if (acc_a) res_a_index <= leaf_index;
            if (acc_b) res_b_index <= leaf_index_two;
        end
    end

`ifdef KDQ_QUERY_ID_EN
    logic [QCNT_W-1:0] id_line_a [LATENCY+1];
    logic [QCNT_W-1:0] id_line_b [LATENCY+1];

    // Free-running id lines: stage 0 lines up with patch_en, the last stage with receiver_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                id_line_a[i] <= '0;
                id_line_b[i] <= '0;
            end
            res_a_id <= '0;
            res_b_id <= '0;
        end else begin
            id_line_a[0] <= issued;
            id_line_b[0] <= issued + QCNT_W'(qa_fire);
            for (int i = 1; i <= LATENCY; i++) begin
                id_line_a[i] <= id_line_a[i-1];
                id_line_b[i] <= id_line_b[i-1];
            end
            if (acc_a) res_a_id <= id_line_a[LATENCY];
            if (acc_b) res_b_id <= id_line_b[LATENCY];
        end
    end
`else
    assign res_a_id = '0;
    assign res_b_id = '0;
`endif

endmodule

// File: tb/tb_kd_tree_query_scheduler.sv
// Self-checking bench for kd_tree_query_scheduler with a fixed-latency tree model and scoreboard queues.
module tb_kd_tree_query_scheduler;
  localparam int IW = 22;
  localparam int PW = 55;
  localparam int AW = 8;
  localparam int QW = 12;
  localparam int NN = 63;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [QW-1:0] num_queries = '0;
  logic busy, done, err, node_ready, qa_ready, qb_ready, fsm_enable, sender_enable;
  logic node_valid = 1'b0;
  logic [IW-1:0] node_data = '0;
  logic qa_valid = 1'b0, qb_valid = 1'b0;
  logic [PW-1:0] qa_patch = '0, qb_patch = '0;
  logic [IW-1:0] sender_data;
  logic patch_en, patch_two_en;
  logic [PW-1:0] patch_in, patch_in_two;
  logic receiver_en, receiver_two_en;
  logic [AW-1:0] leaf_index, leaf_index_two;
  logic res_a_valid, res_b_valid;
  logic [AW-1:0] res_a_index, res_b_index;
  logic [QW-1:0] res_a_id, res_b_id;
  logic inj2 = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kd_tree_query_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .num_queries(num_queries),
    .busy(busy), .done(done), .err(err),
    .node_valid(node_valid), .node_data(node_data), .node_ready(node_ready),
    .qa_valid(qa_valid), .qa_patch(qa_patch), .qa_ready(qa_ready),
    .qb_valid(qb_valid), .qb_patch(qb_patch), .qb_ready(qb_ready),
    .fsm_enable(fsm_enable), .sender_enable(sender_enable), .sender_data(sender_data),
    .patch_en(patch_en), .patch_two_en(patch_two_en),
    .patch_in(patch_in), .patch_in_two(patch_in_two),
    .receiver_en(receiver_en), .receiver_two_en(receiver_two_en),
    .leaf_index(leaf_index), .leaf_index_two(leaf_index_two),
    .res_a_valid(res_a_valid), .res_b_valid(res_b_valid),
    .res_a_index(res_a_index), .res_b_index(res_b_index),
    .res_a_id(res_a_id), .res_b_id(res_b_id)
  );

  // tree model: receiver_* follows patch_* by 6 cycles, leaf = low patch byte ^ 8'hA5
  logic [5:0] pe_sh, pe2_sh;
  logic [AW-1:0] lf_sh [6];
  logic [AW-1:0] lf2_sh [6];
  always @(posedge clk) begin
    if (rst) begin
      pe_sh <= '0;
      pe2_sh <= '0;
      for (int i = 0; i < 6; i++) begin
        lf_sh[i] <= '0;
        lf2_sh[i] <= '0;
      end
    end else begin
      pe_sh <= {pe_sh[4:0], patch_en};
      pe2_sh <= {pe2_sh[4:0], patch_two_en};
      lf_sh[0] <= patch_in[7:0] ^ 8'hA5;
      lf2_sh[0] <= patch_in_two[7:0] ^ 8'hA5;
      for (int i = 1; i < 6; i++) begin
        lf_sh[i] <= lf_sh[i-1];
        lf2_sh[i] <= lf2_sh[i-1];
      end
    end
  end
  assign receiver_en = pe_sh[5];
  assign receiver_two_en = pe2_sh[5] | inj2;
  assign leaf_index = lf_sh[5];
  assign leaf_index_two = lf2_sh[5];

  // scoreboard
  logic [IW-1:0] exp_node_q[$];
  logic [AW-1:0] exp_a_idx[$];
  logic [AW-1:0] exp_b_idx[$];
  logic [QW-1:0] exp_a_id[$];
  logic [QW-1:0] exp_b_id[$];
  int exp_a_cyc[$];
  int exp_b_cyc[$];
  logic [QW-1:0] next_id;
  int sender_cnt, fire_a, fire_b, dual_cnt, split_seen, pe_cnt;
  int res_a_cnt, res_b_cnt, done_cnt, done_cyc, last_hs_cyc;

  always @(negedge clk) begin
    logic [IW-1:0] en;
    logic [AW-1:0] ei;
    logic [QW-1:0] eid;
    int ec;
    #3;
    if (sender_enable) begin
      sender_cnt++;
      vectors++;
      if (exp_node_q.size() == 0) begin
        miscompares++;
        $display("FAIL sender_extra: got %h, expected no sender pulse", sender_data);
      end else begin
        en = exp_node_q.pop_front();
        if (sender_data !== en) begin
          miscompares++;
          $display("FAIL sender_data: got %h, expected %h", sender_data, en);
        end
      end
    end
    if (node_valid && node_ready) begin
      exp_node_q.push_back(node_data);
      last_hs_cyc = cyc;
    end
    if (patch_en || patch_two_en) pe_cnt++;
    if (qa_valid && qb_valid && qa_ready && !qb_ready) split_seen = 1;
    if (qa_valid && qa_ready) begin
      exp_a_idx.push_back(qa_patch[7:0] ^ 8'hA5);
      exp_a_id.push_back(next_id);
      exp_a_cyc.push_back(cyc);
      next_id = next_id + 1'b1;
      fire_a++;
    end
    if (qb_valid && qb_ready) begin
      exp_b_idx.push_back(qb_patch[7:0] ^ 8'hA5);
      exp_b_id.push_back(next_id);
      exp_b_cyc.push_back(cyc);
      next_id = next_id + 1'b1;
      fire_b++;
      if (qa_valid && qa_ready) dual_cnt++;
    end
    if (res_a_valid) begin
      res_a_cnt++;
      vectors++;
      if (exp_a_idx.size() == 0) begin
        miscompares++;
        $display("FAIL res_a_extra: got index %h, expected no result", res_a_index);
      end else begin
        ei = exp_a_idx.pop_front();
        eid = exp_a_id.pop_front();
        ec = exp_a_cyc.pop_front();
`ifndef KDQ_QUERY_ID_EN
        eid = '0;
`endif
        if (res_a_index !== ei || res_a_id !== eid || cyc - ec != 8) begin
          miscompares++;
          $display("FAIL res_a: got idx %h id %0d lat %0d, expected idx %h id %0d lat 8",
                   res_a_index, res_a_id, cyc - ec, ei, eid);
        end
      end
    end
    if (res_b_valid) begin
      res_b_cnt++;
      vectors++;
      if (exp_b_idx.size() == 0) begin
        miscompares++;
        $display("FAIL res_b_extra: got index %h, expected no result", res_b_index);
      end else begin
        ei = exp_b_idx.pop_front();
        eid = exp_b_id.pop_front();
        ec = exp_b_cyc.pop_front();
`ifndef KDQ_QUERY_ID_EN
        eid = '0;
`endif
        if (res_b_index !== ei || res_b_id !== eid || cyc - ec != 8) begin
          miscompares++;
          $display("FAIL res_b: got idx %h id %0d lat %0d, expected idx %h id %0d lat 8",
                   res_b_index, res_b_id, cyc - ec, ei, eid);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // driver tasks
  task automatic do_start(input int nq);
    @(negedge clk);
    sender_cnt = 0; fire_a = 0; fire_b = 0; dual_cnt = 0; split_seen = 0; pe_cnt = 0;
    res_a_cnt = 0; res_b_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    next_id = '0;
    start = 1'b1;
    num_queries = QW'(nq);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_load();
    int cnt = 0;
    int t = 0;
    while (cnt < NN && t < 1000) begin
      @(negedge clk);
      node_valid = ($urandom_range(0, 2) != 0);
      node_data = IW'($urandom);
      #1;
      if (node_valid && node_ready) cnt++;
      t++;
    end
    vectors++;
    if (cnt != NN) begin
      miscompares++;
      $display("FAIL load_timeout: got %0d handshakes, expected %0d", cnt, NN);
    end
    @(negedge clk);
    node_valid = 1'b0;
  endtask

  task automatic run_queries(input logic a_on, input logic b_on, input int budget);
    logic [63:0] r;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
      qa_valid = a_on;
      qb_valid = b_on;
      r = {$urandom, $urandom};
      qa_patch = r[PW-1:0];
      r = {$urandom, $urandom};
      qb_patch = r[PW-1:0];
    end
    qa_valid = 1'b0;
    qb_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    vectors++;
    if ({busy, done, err, node_ready, qa_ready, qb_ready, fsm_enable, sender_enable,
         patch_en, patch_two_en, res_a_valid, res_b_valid} !== 12'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy=%b done=%b err=%b nr=%b, expected all 0", busy, done, err, node_ready);
    end
    vectors++;
    if ({sender_data, patch_in, patch_in_two, res_a_index, res_b_index, res_a_id, res_b_id} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: sender_data=%h patch_in=%h, expected 0", sender_data, patch_in);
    end
    rst = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_start(20);
    do_load();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      qa_valid = 1'b1;
      qa_patch = PW'($urandom);
    end
    @(negedge clk);
    qa_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    vectors++;
    if ({busy, done, err, qa_ready, patch_en, res_a_valid, fsm_enable} !== 7'b0 || patch_in !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_out: busy=%b done=%b patch_en=%b patch_in=%h, expected 0",
               busy, done, patch_en, patch_in);
    end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    vectors++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_done: got %0d done pulses busy=%b, expected 0 and 0", done_cnt, busy);
    end
    exp_node_q.delete();
    exp_a_idx.delete(); exp_a_id.delete(); exp_a_cyc.delete();
    exp_b_idx.delete(); exp_b_id.delete(); exp_b_cyc.delete();
  endtask

  task automatic test_load();
    do_start(2);
    vectors++;
    if (fsm_enable !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL load_enter: fsm_enable=%b busy=%b, expected 1 1", fsm_enable, busy);
    end
    do_load();
    #4;
    vectors++;
    if (sender_cnt != NN || exp_node_q.size() != 0) begin
      miscompares++;
      $display("FAIL load_count: got %0d sender pulses, expected %0d", sender_cnt, NN);
    end
    vectors++;
    if (node_ready !== 1'b0 || fsm_enable !== 1'b0 || qa_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_exit: node_ready=%b fsm_enable=%b qa_ready=%b, expected 0 0 1",
               node_ready, fsm_enable, qa_ready);
    end
    run_queries(1'b1, 1'b0, 60);
    vectors++;
    if (done_cnt != 1 || res_a_cnt != 2) begin
      miscompares++;
      $display("FAIL load_run: got %0d done %0d results, expected 1 2", done_cnt, res_a_cnt);
    end
  endtask

  task automatic test_dual_issue();
    do_start(4);
    do_load();
    run_queries(1'b1, 1'b1, 60);
    vectors++;
    if (fire_a != 2 || fire_b != 2 || dual_cnt != 2) begin
      miscompares++;
      $display("FAIL dual_issue: got a=%0d b=%0d dual=%0d, expected 2 2 2", fire_a, fire_b, dual_cnt);
    end
    vectors++;
    if (res_a_cnt + res_b_cnt != 4 || done_cnt != 1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL dual_results: got %0d results %0d done err=%b, expected 4 1 0",
               res_a_cnt + res_b_cnt, done_cnt, err);
    end
  endtask

  task automatic test_odd_count();
    do_start(3);
    do_load();
    run_queries(1'b1, 1'b1, 60);
    vectors++;
    if (split_seen != 1 || fire_a != 2 || fire_b != 1) begin
      miscompares++;
      $display("FAIL odd_issue: got split=%0d a=%0d b=%0d, expected 1 2 1", split_seen, fire_a, fire_b);
    end
    vectors++;
    if (res_a_cnt + res_b_cnt != 3 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL odd_results: got %0d results %0d done, expected 3 1", res_a_cnt + res_b_cnt, done_cnt);
    end
  endtask

  task automatic test_zero_queries();
    do_start(0);
    do_load();
    run_queries(1'b1, 1'b1, 20);
    vectors++;
    if (pe_cnt != 0 || fire_a + fire_b != 0) begin
      miscompares++;
      $display("FAIL zero_patches: got %0d patch cycles, expected 0", pe_cnt);
    end
    vectors++;
    if (done_cnt != 1 || done_cyc - last_hs_cyc != 2) begin
      miscompares++;
      $display("FAIL zero_done: got %0d done at +%0d, expected 1 at +2", done_cnt, done_cyc - last_hs_cyc);
    end
  endtask

  task automatic test_error();
    int seen = 0;
    do_start(1);
    do_load();
    for (int i = 0; i < 20 && fire_a == 0; i++) begin
      @(negedge clk);
      qa_valid = 1'b1;
      qa_patch = PW'($urandom);
      #4;
    end
    @(negedge clk);
    qa_valid = 1'b0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (receiver_en) begin
        inj2 = 1'b1;
        seen = 1;
      end
    end
    @(negedge clk);
    inj2 = 1'b0;
    vectors++;
    if (seen != 1) begin
      miscompares++;
      $display("FAIL err_return_timeout: got no receiver_en, expected one");
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (err !== 1'b1 || done_cnt != 1 || res_a_cnt != 1 || res_b_cnt != 0) begin
      miscompares++;
      $display("FAIL err_set: err=%b done=%0d ra=%0d rb=%0d, expected 1 1 1 0",
               err, done_cnt, res_a_cnt, res_b_cnt);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b, expected 1", err);
    end
    do_start(0);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got %b, expected 0", err);
    end
    do_load();
    run_queries(1'b0, 1'b0, 20);
    vectors++;
    if (done_cnt != 1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_rerun: done=%0d err=%b, expected 1 0", done_cnt, err);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mid_reset();
    test_load();
    test_dual_issue();
    test_odd_count();
    test_zero_queries();
    test_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
